// File: rtl/cpu_defs.sv
// cpu_defs: shared state encoding, opcode constants and IR field positions for the control sequencer
package cpu_defs;
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_ALU_MAX = 5'b01101;
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;
endpackage

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: 4-to-16 one-hot decoder with enable
module reg_select_decoder (
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [15:0] y
);
    assign y = en ? 16'(1) << sel : 16'h0000;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore fetch/execute sequencer for ALU, MUL/DIV and illegal opcodes
module control_sequencer
    import cpu_defs::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Read,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  alu_op,
    output logic        instr_done,
    output logic        illegal
);
    state_t state, next;
    logic [4:0] opcode;
    logic [3:0] ra, rb, rc, out_sel;
    logic alu_cls, md_cls, legal, out_en, in_en, unused_ir;

    assign opcode = ir[OP_HI:OP_LO];
    assign ra = ir[RA_HI:RA_LO];
    assign rb = ir[RB_HI:RB_LO];
    assign rc = ir[RC_HI:RC_LO];
    assign unused_ir = ^ir[RC_LO-1:0];
    assign alu_cls = opcode <= OP_ALU_MAX;
    assign md_cls = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign legal = alu_cls || md_cls;

    always_ff @(posedge clock or negedge clear)
        if (!clear) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE: next = run ? T0 : IDLE;
            T0: next = T1;
            T1: next = mem_ready ? T2 : T1;
            T2: next = T3;
            T3: next = legal ? T4 : (run ? T0 : IDLE);
            T4: next = T5;
            T5: next = md_cls ? T6 : (run ? T0 : IDLE);
            T6: next = run ? T0 : IDLE;
            default: next = IDLE;
        endcase
    end

    // MUL/DIV reads Ra/Rb while ALU ops read Rb/Rc
    assign out_en = (state == T3 || state == T4) && legal;
    assign out_sel = (state == T3) ? (md_cls ? ra : rb) : (md_cls ? rb : rc);
    assign in_en = (state == T5) && alu_cls;

    reg_select_decoder u_out (.en(out_en), .sel(out_sel), .y(reg_out));
    reg_select_decoder u_in (.en(in_en), .sel(ra), .y(reg_in));

    assign PCout = state == T0;
    assign MARin = state == T0;
    assign IncPC = state == T0;
    assign Zin = state == T0 || state == T4;
    assign PCin = state == T1;
    assign Read = state == T1;
    assign MDRin = state == T1;
    assign Zlowout = state == T1 || state == T5;
    assign MDRout = state == T2;
    assign IRin = state == T2;
    assign Yin = state == T3 && legal;
    assign alu_op = (state == T4) ? opcode : 5'b00000;
    assign LOin = state == T5 && md_cls;
    assign Zhighout = state == T6;
    assign HIin = state == T6;
    assign instr_done = (state == T5 && alu_cls) || state == T6;
    assign illegal = state == T3 && !legal;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer
module tb_control_sequencer;
    logic clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic [15:0] reg_in, reg_out;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read;
    logic Yin, Zin, Zhighout, Zlowout, HIin, LOin, instr_done, illegal;
    logic [4:0] alu_op;
    logic [52:0] obs;
    int checks = 0;
    int errors = 0;

    localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN = 14'h1000, S_INCPC = 14'h0800,
        S_MARIN = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100, S_IRIN = 14'h0080,
        S_READ = 14'h0040, S_YIN = 14'h0020, S_ZIN = 14'h0010, S_ZHIGH = 14'h0008,
        S_ZLOW = 14'h0004, S_HIIN = 14'h0002, S_LOIN = 14'h0001;
    localparam logic [13:0] F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
    localparam logic [13:0] F_T1 = S_ZLOW | S_PCIN | S_READ | S_MDRIN;
    localparam logic [13:0] F_T2 = S_MDROUT | S_IRIN;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .reg_in(reg_in), .reg_out(reg_out), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Read(Read),
        .Yin(Yin), .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIin(HIin),
        .LOin(LOin), .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal)
    );

    assign obs = {reg_in, reg_out, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
                  Yin, Zin, Zhighout, Zlowout, HIin, LOin, alu_op, instr_done, illegal};

    function automatic logic [52:0] mk(input logic [15:0] ri, input logic [15:0] ro,
                                       input logic [13:0] s, input logic [4:0] op,
                                       input logic d, input logic il);
        return {ri, ro, s, op, d, il};
    endfunction

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1);
    end

    task test_reset;
        clear = 0; run = 1; mem_ready = 1; ir = 32'h79300000;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", obs, 53'h0);
        end
        checks++;
        if (dut.state !== cpu_defs::IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d required %0d", dut.state, cpu_defs::IDLE);
        end
        run = 0; clear = 1;
        @(negedge clock);
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL idle_hold: got %h required %h", obs, 53'h0);
        end
    endtask

    task run_div(input int drop_at, input string tag);
        logic [52:0] e [0:6];
        e = '{mk(0, 0, F_T0, 0, 0, 0), mk(0, 0, F_T1, 0, 0, 0), mk(0, 0, F_T2, 0, 0, 0),
              mk(0, 16'h0004, S_YIN, 0, 0, 0), mk(0, 16'h0040, S_ZIN, 5'b01111, 0, 0),
              mk(0, 0, S_ZLOW | S_LOIN, 0, 0, 0), mk(0, 0, S_ZHIGH | S_HIIN, 0, 1, 0)};
        ir = 32'h79300000; mem_ready = 1; run = 1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL %s step %0d: got %h required %h", tag, i, obs, e[i]);
            end
            if (i == drop_at) run = 0;
        end
        @(negedge clock);
        checks++;
        if (obs !== 53'h0 || dut.state !== cpu_defs::IDLE) begin
            errors++;
            $display("FAIL %s idle_after: got %h/%0d required 0/IDLE", tag, obs, dut.state);
        end
    endtask

    task test_div;
        run_div(6, "div");
    endtask

    task test_run_drop;
        run_div(4, "run_drop");
    endtask

    task test_and_wait(input int waits, input string tag);
        logic [52:0] e [0:5];
        e = '{mk(0, 0, F_T0, 0, 0, 0), mk(0, 0, F_T1, 0, 0, 0), mk(0, 0, F_T2, 0, 0, 0),
              mk(0, 16'h0020, S_YIN, 0, 0, 0), mk(0, 16'h0080, S_ZIN, 5'b00101, 0, 0),
              mk(16'h0010, 0, S_ZLOW, 0, 1, 0)};
        ir = 32'h2A2B8000; mem_ready = (waits == 0); run = 1;
        @(negedge clock);
        checks++;
        if (obs !== e[0]) begin
            errors++;
            $display("FAIL %s fetch_t0: got %h required %h", tag, obs, e[0]);
        end
        for (int i = 0; i <= waits; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== e[1]) begin
                errors++;
                $display("FAIL %s t1 cycle %0d: got %h required %h", tag, i, obs, e[1]);
            end
            if (i == waits) mem_ready = 1;
        end
        for (int i = 2; i < 6; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL %s step %0d: got %h required %h", tag, i, obs, e[i]);
            end
            if (i == 5) run = 0;
        end
        @(negedge clock);
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL %s idle_after: got %h required %h", tag, obs, 53'h0);
        end
    endtask

    task test_and;
        test_and_wait(0, "and");
    endtask

    task test_mem_wait;
        test_and_wait(3, "mem_wait");
    endtask

    task test_illegal;
        logic [52:0] e [0:4];
        e = '{mk(0, 0, F_T0, 0, 0, 0), mk(0, 0, F_T1, 0, 0, 0), mk(0, 0, F_T2, 0, 0, 0),
              mk(0, 0, 0, 0, 0, 1), mk(0, 0, F_T0, 0, 0, 0)};
        ir = 32'hF8000000; mem_ready = 1; run = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL illegal step %0d: got %h required %h", i, obs, e[i]);
            end
        end
        run = 0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (obs !== e[i]) begin
                errors++;
                $display("FAIL illegal second step %0d: got %h required %h", i, obs, e[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL illegal idle_after: got %h required %h", obs, 53'h0);
        end
    endtask

    task test_clear_mid;
        ir = 32'h79300000; mem_ready = 1; run = 1;
        repeat (5) @(negedge clock);
        checks++;
        if (obs !== mk(0, 16'h0040, S_ZIN, 5'b01111, 0, 0)) begin
            errors++;
            $display("FAIL clear_mid t4: got %h required %h", obs, mk(0, 16'h0040, S_ZIN, 5'b01111, 0, 0));
        end
        #2 clear = 0;
        #1;
        checks++;
        if (obs !== 53'h0 || dut.state !== cpu_defs::IDLE) begin
            errors++;
            $display("FAIL clear_async: got %h/%0d required 0/IDLE", obs, dut.state);
        end
        @(negedge clock);
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL clear_hold: got %h required %h", obs, 53'h0);
        end
        #2 clear = 1;
        @(negedge clock);
        checks++;
        if (obs !== mk(0, 0, F_T0, 0, 0, 0)) begin
            errors++;
            $display("FAIL clear_release: got %h required %h", obs, mk(0, 0, F_T0, 0, 0, 0));
        end
        mem_ready = 0;
        @(negedge clock);
        clear = 0;
        #1;
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL clear_in_t1_wait: got %h required %h", obs, 53'h0);
        end
        run = 0; mem_ready = 1;
        @(negedge clock);
        clear = 1;
        @(negedge clock);
        checks++;
        if (obs !== 53'h0) begin
            errors++;
            $display("FAIL clear_then_idle: got %h required %h", obs, 53'h0);
        end
    endtask

    initial begin
        run = 0; mem_ready = 0; ir = 0; clear = 0;
        test_reset;
        test_div;
        test_and;
        test_mem_wait;
        test_illegal;
        test_run_drop;
        test_clear_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001: clock  in  1  single system clock; all state changes on the rising edge.
REQ-002: clear  in  1  reset, asynchronous, active-low.
REQ-003: run  in  1  level; high = fetch/execute continuously, low = stop at the next instruction boundary.
REQ-004: ir  in  32  instruction register contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-005: mem_ready  in  1  memory read-data-valid, sampled only in T1.
REQ-006: reg_in / reg_out  out  16 each  one-hot general-register load/drive strobes for R0-R15.
REQ-007: PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Yin, Zin, Zhighout, Zlowout, HIin, LOin  out  1 each  datapath strobes of the same names.
REQ-008: alu_op  out  5  ALU operation select.
REQ-009: instr_done  out  1  one-cycle pulse in the final step of each legal instruction.
REQ-010: illegal  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-011: States: IDLE, T0-T6; all outputs are Moore-decoded from state and ir, asserted for the whole cycle.
REQ-012: IDLE -> T0 when run=1; otherwise stay in IDLE with all outputs 0.
REQ-013: T0 asserts PCout, MARin, IncPC, Zin; then T1.
REQ-014: T1 asserts Zlowout, PCin, Read, MDRin; stays in T1 while mem_ready=0 (re-asserting PCin is idempotent); goes to T2 on mem_ready=1.
REQ-015: T2 asserts MDRout, IRin; then T3.
REQ-016: ALU class (opcode 00000-01101): T3 reg_out[Rb], Yin; T4 reg_out[Rc], Zin, alu_op=opcode; T5 Zlowout, reg_in[Ra], instr_done.
REQ-017: MUL/DIV class (opcode 01110/01111): T3 reg_out[Ra], Yin; T4 reg_out[Rb], Zin, alu_op=opcode; T5 Zlowout, LOin; T6 Zhighout, HIin, instr_done.
REQ-018: Any other opcode: T3 asserts illegal only; no register, HI, LO, or Z activity; next state per REQ-019.
REQ-019: After the final step (T5, T6, or an illegal T3): go to T0 if run=1, else IDLE.
REQ-020: Dropping run mid-instruction has no effect until the instruction boundary; the instruction always completes.
REQ-021: At most one bit of reg_in and at most one bit of reg_out is set per cycle; both are all-zero outside the listed steps.
REQ-022: alu_op = 5'b00000 in every cycle other than T4.
REQ-023: ir is sampled only in T3-T6 and is stable from T2 onward.

Reset
REQ-024: clear=0 forces IDLE immediately, regardless of clock; every output is 0 for as long as clear=0.
REQ-025: After clear is released, the first possible state change is on the next rising edge.
REQ-026: Reset during any state, including a T1 wait, aborts the instruction with no further strobes.

Structure
REQ-027: Shared package cpu_defs holds the state encoding, OP_MUL=5'b01110, OP_DIV=5'b01111, the ALU-class upper bound 5'b01101, and the IR field bit positions.
REQ-028: Sub-module reg_select_decoder: 4-to-16 one-hot decoder with enable; one instance each for reg_in and reg_out.

Verification
REQ-029: DIV: ir=0x79300000, mem_ready=1 -> T3 reg_out[2]+Yin; T4 reg_out[6]+Zin with alu_op=01111; T5 Zlowout+LOin; T6 Zhighout+HIin+instr_done.
REQ-030: AND: ir=0x2A2B8000 -> T3 reg_out[5]+Yin; T4 reg_out[7]+Zin with alu_op=00101; T5 Zlowout+reg_in[4]+instr_done; no HIin/LOin.
REQ-031: mem_ready held low 3 cycles in T1 -> Read/MDRin high for 4 consecutive cycles; IRin appears exactly one cycle after mem_ready rises.
REQ-032: ir opcode 11111 -> illegal pulse in T3; reg_in, HIin, LOin, and Zin all 0; next state T0 with run=1.
REQ-033: clear driven low between clock edges during T4 -> all outputs 0 within the same cycle; state IDLE.
REQ-034: run lowered in T4 of a DIV -> T5 and T6 still execute; IDLE follows T6.
